// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: requester handshakes, register-file write port and read buses of rf_write_arbiter
interface rf_write_arbiter_if #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
);
    logic             req0_valid, req0_ready, req1_valid, req1_ready, hold, wE;
    logic [AW-1:0]    req0_addr, req1_addr, rW, rA, rB;
    logic [DW-1:0]    req0_data, req1_data, busW, rfBusA, rfBusB, busA, busB;
    logic [CNT_W-1:0] conflictCnt;

    modport slave (
        input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
               hold, rA, rB, rfBusA, rfBusB,
        output req0_ready, req1_ready, wE, rW, busW, busA, busB, conflictCnt
    );

    modport master (
        output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
               hold, rA, rB, rfBusA, rfBusB,
        input  req0_ready, req1_ready, wE, rW, busW, busA, busB, conflictCnt
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin sharing of the register-file write port; define RFARB_BYPASS_EN to forward the in-flight write to busA/busB
module rf_write_arbiter #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    rf_write_arbiter_if.slave bus
);
    logic             g0, g1, conflict;
    logic             wE_q, wE_d, last_q, last_d;
    logic [AW-1:0]    rW_q, rW_d;
    logic [DW-1:0]    busW_q, busW_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // grant: hold blocks everyone; a tie goes to the requester that did not win last (last_q=1 means req1 won)
    always_comb begin
        g0       = !bus.hold && bus.req0_valid && (!bus.req1_valid || last_q);
        g1       = !bus.hold && bus.req1_valid && (!bus.req0_valid || !last_q);
        conflict = (bus.req0_valid && !g0) || (bus.req1_valid && !g1);
    end

    // next state: a grant loads the stage, hold freezes it, otherwise only wE drops
    always_comb begin
        wE_d   = bus.hold ? wE_q : 1'b0;
        rW_d   = rW_q;
        busW_d = busW_q;
        last_d = last_q;
        if (g0 || g1) begin
            rW_d   = g1 ? bus.req1_addr : bus.req0_addr;
            busW_d = g1 ? bus.req1_data : bus.req0_data;
            wE_d   = (g1 ? bus.req1_addr : bus.req0_addr) != '0;
            last_d = g1;
        end
        cnt_d = (conflict && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    // state registers; reset drops any pending write immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wE_q   <= 1'b0;
            rW_q   <= '0;
            busW_q <= '0;
            cnt_q  <= '0;
            last_q <= 1'b1;
        end else begin
            wE_q   <= wE_d;
            rW_q   <= rW_d;
            busW_q <= busW_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign bus.req0_ready  = g0;
    assign bus.req1_ready  = g1;
    assign bus.wE          = wE_q;
    assign bus.rW          = rW_q;
    assign bus.busW        = busW_q;
    assign bus.conflictCnt = cnt_q;

`ifdef RFARB_BYPASS_EN
    assign bus.busA = (wE_q && rW_q == bus.rA && bus.rA != '0) ? busW_q : bus.rfBusA;
    assign bus.busB = (wE_q && rW_q == bus.rB && bus.rB != '0) ? busW_q : bus.rfBusB;
`else
    logic unused_rd;
    assign unused_rd = ^{bus.rA, bus.rB};
    assign bus.busA  = bus.rfBusA;
    assign bus.busB  = bus.rfBusB;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: vector table, corner sequences and randomized reference-model check of rf_write_arbiter
module tb_rf_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    rf_write_arbiter_if #(.DW(32), .AW(5), .CNT_W(16)) bus ();
    rf_write_arbiter_if #(.DW(32), .AW(5), .CNT_W(3))  sbus ();

    rf_write_arbiter #(.DW(32), .AW(5), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
    rf_write_arbiter #(.DW(32), .AW(5), .CNT_W(3))  sdut (.clk(clk), .rst(rst), .bus(sbus));

    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        hold;
        logic        r0, r1, we;
        logic [4:0]  rw;
        logic [31:0] bw;
        int          cnt;
    } vec_t;

    vec_t tbl[11];

    // reference model: plain arithmetic over the arbitration rules
    int          m_last, m_cnt;
    logic        m_we, m_r0, m_r1, a_r0, a_r1;
    logic [4:0]  m_rw;
    logic [31:0] m_bw, exp_a, exp_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 1;
        m_we   = 1'b0;
        m_rw   = '0;
        m_bw   = '0;
        m_cnt  = 0;
    endtask

    // sample readies mid-cycle, advance the model, then step past the next posedge
    task automatic tick();
        int g, nv;
        #1;
        a_r0 = bus.req0_ready;
        a_r1 = bus.req1_ready;
        g = -1;
        if (!bus.hold) begin
            if (bus.req0_valid && bus.req1_valid) g = 1 - m_last;
            else if (bus.req0_valid) g = 0;
            else if (bus.req1_valid) g = 1;
        end
        nv = int'(bus.req0_valid) + int'(bus.req1_valid);
        if (nv > (g >= 0 ? 1 : 0) && m_cnt < 65535) m_cnt++;
        m_r0 = (g == 0);
        m_r1 = (g == 1);
        if (g >= 0) begin
            m_rw   = g ? bus.req1_addr : bus.req0_addr;
            m_bw   = g ? bus.req1_data : bus.req0_data;
            m_we   = (m_rw != 0);
            m_last = g;
        end else if (!bus.hold) m_we = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1, input logic hold);
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        bus.req1_data  = d1;
        bus.hold       = hold;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        bus.rA = '0; bus.rB = '0; bus.rfBusA = '0; bus.rfBusB = '0;
        sbus.req0_valid = 1'b1; sbus.req0_addr = 5'd1; sbus.req0_data = 32'h1;
        sbus.req1_valid = 1'b0; sbus.req1_addr = '0; sbus.req1_data = '0;
        sbus.hold = 1'b1; sbus.rA = '0; sbus.rB = '0; sbus.rfBusA = '0; sbus.rfBusB = '0;
        model_reset();

        tbl[0]  = '{1, 8, 32'h1234, 0, 0, 0, 0,            1, 0, 1, 8, 32'h1234, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 8, 32'h1234, 0};
        tbl[2]  = '{0, 0, 0, 1, 3, 32'h3, 0,               0, 1, 1, 3, 32'h3, 0};
        tbl[3]  = '{1, 9, 32'h99, 1, 10, 32'hAA, 0,        1, 0, 1, 9, 32'h99, 1};
        tbl[4]  = '{1, 9, 32'h99, 1, 10, 32'hAA, 0,        0, 1, 1, 10, 32'hAA, 2};
        tbl[5]  = '{1, 9, 32'h99, 1, 10, 32'hAA, 0,        1, 0, 1, 9, 32'h99, 3};
        tbl[6]  = '{1, 9, 32'h99, 1, 10, 32'hAA, 0,        0, 1, 1, 10, 32'hAA, 4};
        tbl[7]  = '{1, 4, 32'h44, 0, 0, 0, 0,              1, 0, 1, 4, 32'h44, 4};
        tbl[8]  = '{0, 0, 0, 1, 0, 32'hFFFF, 0,            0, 1, 0, 0, 32'hFFFF, 4};
        tbl[9]  = '{1, 5, 32'h55, 1, 6, 32'h66, 0,         1, 0, 1, 5, 32'h55, 5};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 5, 32'h55, 5};

        repeat (2) @(posedge clk);
        #1;
        chk("rst wE", bus.wE, 0);
        chk("rst rW", bus.rW, 0);
        chk("rst busW", bus.busW, 0);
        chk("rst cnt", bus.conflictCnt, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1, tbl[i].hold);
            tick();
            chk($sformatf("vec%0d r0", i), a_r0, tbl[i].r0);
            chk($sformatf("vec%0d r1", i), a_r1, tbl[i].r1);
            chk($sformatf("vec%0d wE", i), bus.wE, tbl[i].we);
            chk($sformatf("vec%0d rW", i), bus.rW, tbl[i].rw);
            chk($sformatf("vec%0d busW", i), bus.busW, tbl[i].bw);
            chk($sformatf("vec%0d cnt", i), bus.conflictCnt, tbl[i].cnt);
        end

        // asynchronous reset in the middle of a cycle with a write in flight
        drive(1, 7, 32'h77, 0, 0, 0, 0);
        tick();
        chk("pre-rst wE", bus.wE, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst wE", bus.wE, 0);
        chk("async rst rW", bus.rW, 0);
        chk("async rst busW", bus.busW, 0);
        chk("async rst cnt", bus.conflictCnt, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 32'h11, 1, 2, 32'h22, 0);
        tick();
        chk("tie after rst r0", a_r0, 1);
        chk("tie after rst r1", a_r1, 0);
        chk("tie after rst rW", bus.rW, 1);
        drive(0, 0, 0, 1, 2, 32'h22, 0);
        tick();
        chk("loser re-presented r1", a_r1, 1);
        chk("loser rW", bus.rW, 2);

        // hold freezes the write stage and counts the denied requester each cycle
        drive(1, 8, 32'h88, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold r0", a_r0, 0);
            chk("hold wE", bus.wE, 1);
            chk("hold rW", bus.rW, 2);
            chk("hold busW", bus.busW, 32'h22);
        end
        chk("hold cnt", bus.conflictCnt, 4);
        bus.hold = 1'b0;
        tick();
        chk("unhold r0", a_r0, 1);
        chk("unhold rW", bus.rW, 8);
        chk("unhold busW", bus.busW, 32'h88);

        // read bypass of the in-flight write
        drive(1, 12, 32'hABCD, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        bus.rA = 5'd12; bus.rfBusA = 32'h4; bus.rB = 5'd3; bus.rfBusB = 32'h5;
        #1;
`ifdef RFARB_BYPASS_EN
        chk("bypass busA", bus.busA, 32'hABCD);
`else
        chk("bypass busA", bus.busA, 32'h4);
`endif
        chk("bypass busB miss", bus.busB, 32'h5);
        bus.rA = 5'd0;
        #1;
        chk("bypass rA=0", bus.busA, 32'h4);
        bus.hold = 1'b0;

        // randomized traffic against the reference model
        for (int i = 0; i < 500; i++) begin
            if (!(bus.req0_valid && !a_r0)) begin
                bus.req0_valid = 1'($urandom_range(0, 1));
                bus.req0_addr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                bus.req0_data  = $urandom;
            end
            if (!(bus.req1_valid && !a_r1)) begin
                bus.req1_valid = 1'($urandom_range(0, 1));
                bus.req1_addr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                bus.req1_data  = $urandom;
            end
            bus.hold   = ($urandom_range(0, 7) == 0);
            bus.rA     = 5'($urandom_range(0, 31));
            bus.rB     = 5'($urandom_range(0, 31));
            bus.rfBusA = $urandom;
            bus.rfBusB = $urandom;
            tick();
            chk("rand r0", a_r0, m_r0);
            chk("rand r1", a_r1, m_r1);
            chk("rand wE", bus.wE, m_we);
            chk("rand rW", bus.rW, m_rw);
            chk("rand busW", bus.busW, m_bw);
            chk("rand cnt", bus.conflictCnt, m_cnt);
            exp_a = bus.rfBusA;
            exp_b = bus.rfBusB;
`ifdef RFARB_BYPASS_EN
            if (m_we && m_rw == bus.rA && bus.rA != 0) exp_a = m_bw;
            if (m_we && m_rw == bus.rB && bus.rB != 0) exp_b = m_bw;
`endif
            chk("rand busA", bus.busA, exp_a);
            chk("rand busB", bus.busB, exp_b);
        end

        // counter saturation on the narrow-counter instance (held requester counts every cycle)
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sat cnt 3", sbus.conflictCnt, 3);
        chk("sat ready", sbus.req0_ready, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("sat cnt max", sbus.conflictCnt, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
